// File: rtl/axis_word_packer_if.sv
// axis_word_packer_if
// Bundles the word-strobe input side and the 256-bit AXI-Stream output side
// of axis_word_packer.
//   master : the environment (word source plus downstream stream sink)
//   slave  : the packer itself
// Optional macro AXIS_PACKER_TLAST_EN adds m_axis_tlast to the stream side.
interface axis_word_packer_if #(
   parameter int WORD_W = 16,
   parameter int WORDS  = 16
) ();
   logic                      in_valid;
   logic [WORD_W-1:0]         in_data;
   logic                      in_ready;
   logic                      flush;
   logic [WORD_W*WORDS-1:0]   m_axis_tdata;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;
`ifdef AXIS_PACKER_TLAST_EN
   logic                      m_axis_tlast;

   modport master (
      output in_valid, in_data, flush, m_axis_tready,
      input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
   modport slave (
      input  in_valid, in_data, flush, m_axis_tready,
      output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );
`else
   modport master (
      output in_valid, in_data, flush, m_axis_tready,
      input  in_ready, m_axis_tdata, m_axis_tvalid
   );
   modport slave (
      input  in_valid, in_data, flush, m_axis_tready,
      output in_ready, m_axis_tdata, m_axis_tvalid
   );
`endif
endinterface

// File: rtl/axis_word_packer.sv
// axis_word_packer
// Packs 16-bit words from a non-stallable strobe source into 256-bit
// AXI-Stream beats. A flush emits the current partial beat with the unfilled
// lanes zeroed. Words arriving while the accumulator is full and the output
// register is blocked are counted in dropped_words (saturating).
// Optional macro AXIS_PACKER_TLAST_EN: adds m_axis_tlast, set on any beat
// produced while a flush was pending or arriving.
module axis_word_packer #(
   parameter int WORD_W = 16,
   parameter int WORDS  = 16
) (
   input  logic               axis_clk,
   input  logic               rst,
   axis_word_packer_if.slave  bus,
   output logic [31:0]        sent_beats,
   output logic [15:0]        dropped_words
);

   localparam int CNT_W = $clog2(WORDS);
   localparam int BEAT_W = WORD_W * WORDS;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

   // Controller states; the flush-pending flag is the FLUSH_WAIT state itself.
   localparam logic [1:0] ST_EMPTY      = 2'd0;
   localparam logic [1:0] ST_FILL       = 2'd1;
   localparam logic [1:0] ST_FLUSH_WAIT = 2'd2;

   logic [1:0]                   state_r;
   logic [CNT_W-1:0]             cnt_r;
   logic [WORDS-1:0][WORD_W-1:0] acc_r;
   logic [BEAT_W-1:0]            tdata_r;
   logic                         tvalid_r;
   logic [31:0]                  sent_r;
   logic [15:0]                  drop_r;
`ifdef AXIS_PACKER_TLAST_EN
   logic                         tlast_r;
`endif

   logic                         fp_s;
   logic                         slot_free_s;
   logic                         in_ready_s;
   logic                         accept_s;
   logic                         drop_s;
   logic                         full_load_s;
   logic                         flush_req_s;
   logic                         partial_s;
   logic                         load_s;
   logic [CNT_W-1:0]             cnt_inc_s;
   logic [CNT_W-1:0]             cnt_next_s;
   logic                         fp_next_s;
   logic [1:0]                   state_next_s;
   logic [WORDS-1:0][WORD_W-1:0] acc_ins_s;

   // Decode the flush-pending flag from the controller state.
   always_comb begin
      fp_s = 1'b0;
      case (state_r)
         ST_FLUSH_WAIT: fp_s = 1'b1;
         ST_EMPTY:      fp_s = 1'b0;
         ST_FILL:       fp_s = 1'b0;
         default:       fp_s = 1'b0;
      endcase
   end

   // Input acceptance: only the last lane can stall, and only while the held beat is blocked.
   always_comb begin
      slot_free_s = !tvalid_r || bus.m_axis_tready;
      in_ready_s  = !((cnt_r == LAST_IDX) && !slot_free_s);
      accept_s    = bus.in_valid && in_ready_s;
      drop_s      = bus.in_valid && !in_ready_s;
      full_load_s = accept_s && (cnt_r == LAST_IDX);
      flush_req_s = fp_s || bus.flush;
   end

   // Insert the accepted word first, then decide whether a flush emits the result.
   always_comb begin
      acc_ins_s = acc_r;
      if (accept_s) begin
         acc_ins_s[cnt_r] = bus.in_data;
      end else begin
         acc_ins_s = acc_r;
      end

      if (full_load_s) begin
         cnt_inc_s = '0;
      end else if (accept_s) begin
         cnt_inc_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_inc_s = cnt_r;
      end

      partial_s = flush_req_s && slot_free_s && (cnt_inc_s != '0) && !full_load_s;
      load_s    = full_load_s || partial_s;

      if (load_s) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_inc_s;
      end
   end

   // Next flush-pending flag and controller state.
   always_comb begin
      if (load_s) begin
         fp_next_s = 1'b0;
      end else if ((cnt_r == '0) && !accept_s) begin
         fp_next_s = 1'b0;
      end else if (bus.flush) begin
         fp_next_s = 1'b1;
      end else begin
         fp_next_s = fp_s;
      end

      if (fp_next_s) begin
         state_next_s = ST_FLUSH_WAIT;
      end else if (cnt_next_s == '0) begin
         state_next_s = ST_EMPTY;
      end else begin
         state_next_s = ST_FILL;
      end
   end

   // Controller state, write index and accumulator lanes.
   always_ff @(posedge axis_clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         cnt_r   <= '0;
         acc_r   <= '0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         if (load_s) begin
            acc_r <= '0;
         end else begin
            acc_r <= acc_ins_s;
         end
      end
   end

   // Output beat register; a new beat may load in the cycle the old one transfers.
   always_ff @(posedge axis_clk or posedge rst) begin
      if (rst) begin
         tdata_r  <= '0;
         tvalid_r <= 1'b0;
`ifdef AXIS_PACKER_TLAST_EN
         tlast_r  <= 1'b0;
`endif
      end else if (load_s) begin
         tdata_r  <= acc_ins_s;
         tvalid_r <= 1'b1;
`ifdef AXIS_PACKER_TLAST_EN
         tlast_r  <= flush_req_s;
`endif
      end else if (tvalid_r && bus.m_axis_tready) begin
         tvalid_r <= 1'b0;
      end
   end

   // Transferred-beat counter (wraps) and dropped-word counter (saturates).
   always_ff @(posedge axis_clk or posedge rst) begin
      if (rst) begin
         sent_r <= 32'd0;
         drop_r <= 16'd0;
      end else begin
         if (tvalid_r && bus.m_axis_tready) begin
            sent_r <= sent_r + 32'd1;
         end
         if (drop_s && (drop_r != 16'hFFFF)) begin
            drop_r <= drop_r + 16'd1;
         end
      end
   end

   assign bus.in_ready      = in_ready_s;
   assign bus.m_axis_tdata  = tdata_r;
   assign bus.m_axis_tvalid = tvalid_r;
`ifdef AXIS_PACKER_TLAST_EN
   assign bus.m_axis_tlast  = tlast_r;
`endif
   assign sent_beats        = sent_r;
   assign dropped_words     = drop_r;

endmodule

// File: tb/tb_axis_word_packer.sv
// tb_axis_word_packer
// Directed and random stimulus against a queue-based reference model of the
// packer. Honours AXIS_PACKER_TLAST_EN when defined.
module tb_axis_word_packer;

   localparam int W = 16;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sent_beats;
   logic [15:0] dropped_words;

   axis_word_packer_if #(.WORD_W(W), .WORDS(N)) bus ();

   axis_word_packer #(.WORD_W(W), .WORDS(N)) dut (
      .axis_clk      (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .sent_beats    (sent_beats),
      .dropped_words (dropped_words)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [15:0]  mq[$];
   logic         m_fp;
   logic         m_valid;
   logic         m_last;
   logic [255:0] m_data;
   logic [31:0]  m_sent;
   logic [15:0]  m_drop;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fp    = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = '0;
      m_sent  = 32'd0;
      m_drop  = 16'd0;
   endtask

   task automatic check_outputs();
      chk("tvalid", 256'(bus.m_axis_tvalid), 256'(m_valid));
      if (m_valid) begin
         chk("tdata", bus.m_axis_tdata, m_data);
`ifdef AXIS_PACKER_TLAST_EN
         chk("tlast", 256'(bus.m_axis_tlast), 256'(m_last));
`endif
      end
      chk("sent_beats", 256'(sent_beats), 256'(m_sent));
      chk("dropped_words", 256'(dropped_words), 256'(m_drop));
   endtask

   // one clock cycle: drive at negedge, check in_ready, clock, update model, check outputs
   task automatic step(input logic v, input logic [15:0] d, input logic f, input logic r);
      logic         slot;
      logic         rdy;
      logic [255:0] beat;
      @(negedge clk);
      bus.in_valid      = v;
      bus.in_data       = d;
      bus.flush         = f;
      bus.m_axis_tready = r;
      #1;
      slot = !m_valid || r;
      rdy  = !((mq.size() == N - 1) && !slot);
      chk("in_ready", 256'(bus.in_ready), 256'(rdy));
      @(posedge clk);
      #1;
      if (m_valid && r) m_sent = m_sent + 32'd1;
      if (v && !rdy && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
      if (v && rdy) mq.push_back(d);
      if ((mq.size() == N) || ((m_fp || f) && slot && (mq.size() > 0))) begin
         beat = '0;
         foreach (mq[k]) beat[16*k +: 16] = mq[k];
         m_data  = beat;
         m_valid = 1'b1;
         m_last  = m_fp || f;
         mq.delete();
         m_fp    = 1'b0;
      end else begin
         if (m_valid && r) m_valid = 1'b0;
         if (mq.size() == 0) m_fp = 1'b0;
         else if (f) m_fp = 1'b1;
      end
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst               = 1'b1;
      bus.in_valid      = 1'b0;
      bus.in_data       = 16'h0000;
      bus.flush         = 1'b0;
      bus.m_axis_tready = 1'b0;
      model_reset();
      #1;
      chk("rst_tvalid", 256'(bus.m_axis_tvalid), 256'(1'b0));
      chk("rst_tdata", bus.m_axis_tdata, 256'h0);
      chk("rst_sent", 256'(sent_beats), 256'h0);
      chk("rst_dropped", 256'(dropped_words), 256'h0);
      chk("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
`ifdef AXIS_PACKER_TLAST_EN
      chk("rst_tlast", 256'(bus.m_axis_tlast), 256'(1'b0));
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] sent0;
      logic [15:0] drop0;
      logic [15:0] first_w;
      rst               = 1'b1;
      bus.in_valid      = 1'b0;
      bus.in_data       = 16'h0000;
      bus.flush         = 1'b0;
      bus.m_axis_tready = 1'b0;
      model_reset();
      do_reset();

      // T1: 16 words 1..16 form one beat
      for (int i = 1; i <= 16; i++) step(1'b1, 16'(i), 1'b0, 1'b1);
      chk("t1_tvalid", 256'(bus.m_axis_tvalid), 256'(1'b1));
      chk("t1_lane0", 256'(bus.m_axis_tdata[15:0]), 256'h0001);
      chk("t1_lane15", 256'(bus.m_axis_tdata[255:240]), 256'h0010);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t1_sent", 256'(sent_beats), 256'd1);

      // T2: 3 words then flush -> zero-padded partial beat
      step(1'b1, 16'h000A, 1'b0, 1'b1);
      step(1'b1, 16'h000B, 1'b0, 1'b1);
      step(1'b1, 16'h000C, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("t2_partial", bus.m_axis_tdata, 256'h000C000B000A);
`ifdef AXIS_PACKER_TLAST_EN
      chk("t2_tlast", 256'(bus.m_axis_tlast), 256'(1'b1));
`endif
      step(1'b0, 16'h0000, 1'b0, 1'b1);

      // T3: back-pressure with a full beat held: 15 accepted, 5 dropped
      for (int i = 0; i < 16; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      chk("t3_dropped", 256'(dropped_words), 256'd5);
      chk("t3_in_ready_low", 256'(bus.in_ready), 256'(1'b0));
      step(1'b1, 16'h0300, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);

      // T4: flush with nothing accumulated is discarded; flush with first word
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      chk("t4_no_beat", 256'(bus.m_axis_tvalid), 256'(1'b0));
      step(1'b1, 16'h0055, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t4_fp_cleared", 256'(bus.m_axis_tvalid), 256'(1'b0));
      step(1'b0, 16'h0000, 1'b1, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b1, 16'h0077, 1'b1, 1'b1);
      chk("t4_one_word", bus.m_axis_tdata, 256'h0077);
      step(1'b0, 16'h0000, 1'b0, 1'b1);

      // T5: 64 streamed words -> 4 back-to-back beats, no drops
      sent0 = sent_beats;
      drop0 = dropped_words;
      for (int i = 0; i < 64; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("t5_sent", 256'(sent_beats), 256'(sent0 + 32'd4));
      chk("t5_dropped", 256'(dropped_words), 256'(drop0));

      // T6: reset mid-beat, then a fresh beat starts at lane 0
      for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
      do_reset();
      first_w = 16'($urandom);
      step(1'b1, first_w, 1'b0, 1'b1);
      for (int i = 1; i < 16; i++) step(1'b1, 16'($urandom), 1'b0, 1'b1);
      chk("t6_lane0", 256'(bus.m_axis_tdata[15:0]), 256'(first_w));
      step(1'b0, 16'h0000, 1'b0, 1'b1);

      // Random traffic: bursts, flushes and back-pressure
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 9) < 8),
              16'($urandom),
              1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_word_packer.md
# axis_word_packer

Transmit-side companion to the AXI-Stream FIFO wrappers. Collects 16-bit words from a PS-side strobe interface (GPIO-style, non-stallable source) and packs them into 256-bit AXI-Stream beats that drive the slave port of the sync FIFO wrapper. A flush request emits a zero-padded partial beat. Words that cannot be accepted are counted, not silently lost.

## Interface
- `WORD_W`, 16: input word width.
- `WORDS`, 16: words per beat. `WORD_W*WORDS` must equal 256.
- `axis_clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: word strobe. One word per cycle while high.
- `in_data` in `WORD_W`: word payload.
- `in_ready` out 1: the word presented this cycle is accepted.
- `flush` in 1: single-cycle request to emit the current partial beat.
- `m_axis_tdata` out 256: packed beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream accept.
- `sent_beats` out 32: count of beats transferred (tvalid && tready). Wraps.
- `dropped_words` out 16: count of cycles with in_valid && !in_ready. Saturates at 0xFFFF.

## Operation
- Accumulator with write index `cnt` (0..WORDS-1), plus one output register (`m_axis_tdata`/`m_axis_tvalid`).
- Lane mapping: the k-th word accepted into a beat occupies bits [WORD_W*k+WORD_W-1 : WORD_W*k]. The first word goes to lane 0.
- Output slot free = !m_axis_tvalid || m_axis_tready.
- Acceptance: `in_ready` = !(cnt==WORDS-1 && !slot_free). This is combinational from `cnt`, `m_axis_tvalid` and `m_axis_tready`.
- Beat completion: accepting a word at cnt==WORDS-1 loads the output register with the full beat and sets cnt to 0.
- Flush pending flag `fp`:
  - Set by `flush`.
  - Cleared when a beat is loaded.
  - Also cleared if cnt==0 and no word is accepted that cycle; a flush with nothing accumulated is discarded.
- Partial emit: when (fp || flush) && slot_free && cnt_next>0 && no full-beat load occurs, the output register loads the accumulator with unfilled lanes zeroed, and cnt goes to 0.
- Simultaneous flush and accepted word: the word is included first, then the flush applies to the result.
- Accumulator lanes are cleared to zero when a beat is loaded.
- State machine:
  - EMPTY (cnt==0, !fp).
  - FILL (cnt>0, !fp).
  - FLUSH_WAIT (fp, waiting for slot_free).
  - Transitions:
    - EMPTY→FILL on an accepted word.
    - FILL→EMPTY on full-beat load.
    - FILL→FLUSH_WAIT on flush while !slot_free.
    - FLUSH_WAIT→EMPTY on partial emit.
    - FLUSH_WAIT accepts words normally. If this completes a full beat, the full beat is emitted and fp clears.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, cnt=0, fp=0, sent_beats=0, dropped_words=0. `in_ready` evaluates to 1 out of reset. Reset mid-beat discards accumulated words and any held output beat.
- Latency: the word completing a beat, or a flush with slot free, produces m_axis_tvalid=1 on the next cycle.
- AXIS rules:
  - m_axis_tdata is stable while tvalid && !tready.
  - tvalid does not depend on tready.
  - A new beat may load in the same cycle the previous one transfers, giving back-to-back beats.
- Sustained throughput: one word per cycle with tready=1, with no drops.

## Configuration
- `AXIS_PACKER_TLAST_EN`:
  - Defined: adds output `m_axis_tlast` (1 bit, reset 0), loaded with the beat. It is 1 for any beat produced while a flush was pending or arriving, including a full beat that absorbed the flush, and 0 otherwise.
  - Undefined: the port and its register do not exist; behaviour is otherwise identical.

## Test plan
- Feed 16 words 0x0001..0x0010 with tready=1 → one beat, lane0=0x0001, lane15=0x0010, tvalid high one cycle after the 16th word, sent_beats=1.
- Feed 3 words 0xA, 0xB, 0xC, then pulse flush → beat lanes0..2 = 0xA/0xB/0xC, lanes 3..15 = 0; tlast=1 when the macro is defined.
- Hold tready=0 with a full beat pending and feed 20 words → 15 accepted, then in_ready=0 and dropped_words=5. Raise tready → the first beat transfers and the next word is accepted.
- Flush pulse with cnt==0 and no word → no beat, fp returns to 0. Flush in the same cycle as the first word → one 1-word beat.
- Stream 64 words with tready=1 → 4 back-to-back beats, dropped_words=0, sent_beats=4.
- Assert rst after 7 words → outputs return to reset values. The next 16 words form one beat starting at lane 0.
